// File: rtl/fetch_decode_sequencer_pkg.sv
// Shared definitions for the fetch/decode/execute sequencer: opcode class
// nibbles, data_bus source encodings, FSM states and the branch rule.
package fetch_decode_sequencer_pkg;

    localparam int          DATA_WIDTH = 16;
    localparam logic [15:0] HALT_WORD  = 16'hFFFF;

    // Opcode class nibbles found in opcode[15:12]
    localparam logic [3:0] ALU_OP = 4'h1;
    localparam logic [3:0] ROM_OP = 4'h3;
    localparam logic [3:0] RAM_OP = 4'h4;
    localparam logic [3:0] PC_OP  = 4'h7;

    typedef enum logic [1:0] {
        BUS_PC  = 2'b00,
        BUS_ALU = 2'b01,
        BUS_RAM = 2'b10,
        BUS_IMM = 2'b11
    } bus_sel_e;

    typedef enum logic [2:0] {
        FETCH   = 3'd0,
        DECODE  = 3'd1,
        EXECUTE = 3'd2,
        ADVANCE = 3'd3,
        HALT    = 3'd4,
        FAULT   = 3'd5
    } state_e;

    typedef enum logic [1:0] {
        CLS_ALU = 2'd0,
        CLS_ROM = 2'd1,
        CLS_RAM = 2'd2,
        CLS_PC  = 2'd3
    } op_class_e;

    // A zero mask is an unconditional branch; otherwise any matching flag takes it.
    function automatic logic branch_taken(input logic [3:0] mask, input logic [3:0] flags);
        return (mask == 4'h0) || ((mask & flags) != 4'h0);
    endfunction

endpackage

// File: rtl/fetch_decode_sequencer_if.sv
// Bus bundle between the sequencer and the ROM/RAM/ALU/PC blocks.
// master = sequencer side, slave = the surrounding datapath.
interface fetch_decode_sequencer_if #(
    parameter int DATA_WIDTH = 16
);
    logic [DATA_WIDTH-1:0] rom_opcode;
    logic [DATA_WIDTH-1:0] rom_operand;
    logic [3:0]            flags;
    logic                  ram_ready;

    logic [DATA_WIDTH-1:0] ir_opcode;
    logic [DATA_WIDTH-1:0] ir_operand;
    logic                  alu_en;
    logic                  ram_re;
    logic                  ram_we;
    logic                  pc_load;
    logic                  pc_inc;
    logic [1:0]            bus_sel;
    logic                  halted;
    logic                  fault;
    logic [15:0]           instr_count;

    modport master (
        input  rom_opcode, rom_operand, flags, ram_ready,
        output ir_opcode, ir_operand, alu_en, ram_re, ram_we,
               pc_load, pc_inc, bus_sel, halted, fault, instr_count
    );

    modport slave (
        output rom_opcode, rom_operand, flags, ram_ready,
        input  ir_opcode, ir_operand, alu_en, ram_re, ram_we,
               pc_load, pc_inc, bus_sel, halted, fault, instr_count
    );

endinterface

// File: rtl/fetch_decode_sequencer_instr_decoder.sv
// Combinational classification of the latched instruction word.
module fetch_decode_sequencer_instr_decoder #(
    parameter int                    DATA_WIDTH = 16,
    parameter logic [DATA_WIDTH-1:0] HALT_WORD  = '1
) (
    input  logic [DATA_WIDTH-1:0]                 opcode,
    output fetch_decode_sequencer_pkg::op_class_e op_class,
    output logic                                  illegal,
    output logic                                  is_halt,
    output logic                                  is_write,
    output logic [3:0]                            branch_mask
);
    import fetch_decode_sequencer_pkg::*;

    // Map the top nibble onto an instruction class; unknown nibbles are illegal.
    always_comb begin
        op_class = CLS_ALU;
        illegal  = 1'b0;
        case (opcode[DATA_WIDTH-1 -: 4])
            ALU_OP:  op_class = CLS_ALU;
            ROM_OP:  op_class = CLS_ROM;
            RAM_OP:  op_class = CLS_RAM;
            PC_OP:   op_class = CLS_PC;
            default: illegal  = 1'b1;
        endcase
    end

    assign is_halt     = (opcode == HALT_WORD);
    assign is_write    = opcode[0];
    assign branch_mask = opcode[3:0];

endmodule

// File: rtl/fetch_decode_sequencer.sv
// Fetch/decode/execute controller. Latches the ROM word, classifies it and
// issues single-cycle ALU/PC strobes, held RAM requests and the data_bus
// source select. All outputs are decoded from registered state.
module fetch_decode_sequencer #(
    parameter int                    DATA_WIDTH  = fetch_decode_sequencer_pkg::DATA_WIDTH,
    parameter int                    RAM_TIMEOUT = 8,
    parameter logic [DATA_WIDTH-1:0] HALT_WORD   = fetch_decode_sequencer_pkg::HALT_WORD
) (
    input  logic                     clk,
    input  logic                     reset,
    fetch_decode_sequencer_if.master bus
);
    import fetch_decode_sequencer_pkg::*;

    // Request cycle index at which a still-unanswered RAM access gives up.
    localparam logic [7:0] WAIT_LAST = 8'(RAM_TIMEOUT - 1);

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] ir_opcode_q, ir_opcode_d;
    logic [DATA_WIDTH-1:0] ir_operand_q, ir_operand_d;
    logic [15:0]           instr_count_q, instr_count_d;
    logic [7:0]            wait_cnt_q, wait_cnt_d;
    logic                  taken_q, taken_d;

    op_class_e             op_class;
    logic                  illegal;
    logic                  is_halt;
    logic                  is_write;
    logic [3:0]            branch_mask;

    logic                  alu_en;
    logic                  ram_re;
    logic                  ram_we;
    logic                  pc_load;
    logic                  pc_inc;
    bus_sel_e              bus_sel;

    fetch_decode_sequencer_instr_decoder #(
        .DATA_WIDTH (DATA_WIDTH),
        .HALT_WORD  (HALT_WORD)
    ) u_decoder (
        .opcode      (ir_opcode_q),
        .op_class    (op_class),
        .illegal     (illegal),
        .is_halt     (is_halt),
        .is_write    (is_write),
        .branch_mask (branch_mask)
    );

    // State and instruction registers; reset aborts any instruction in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= FETCH;
            ir_opcode_q   <= '0;
            ir_operand_q  <= '0;
            instr_count_q <= '0;
            wait_cnt_q    <= '0;
            taken_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            ir_opcode_q   <= ir_opcode_d;
            ir_operand_q  <= ir_operand_d;
            instr_count_q <= instr_count_d;
            wait_cnt_q    <= wait_cnt_d;
            taken_q       <= taken_d;
        end
    end

    // Next-state logic plus Moore outputs decoded from the registered state.
    always_comb begin
        state_d       = state_q;
        ir_opcode_d   = ir_opcode_q;
        ir_operand_d  = ir_operand_q;
        instr_count_d = instr_count_q;
        wait_cnt_d    = wait_cnt_q;
        taken_d       = taken_q;

        alu_en  = 1'b0;
        ram_re  = 1'b0;
        ram_we  = 1'b0;
        pc_load = 1'b0;
        pc_inc  = 1'b0;
        bus_sel = BUS_PC;

        case (state_q)
            FETCH: begin
                // PC drives the bus so the ROM presents the word at the current PC.
                ir_opcode_d  = bus.rom_opcode;
                ir_operand_d = bus.rom_operand;
                taken_d      = 1'b0;
                wait_cnt_d   = '0;
                state_d      = DECODE;
            end

            DECODE: begin
                // Flags are sampled here so the branch strobe stays a registered decode.
                wait_cnt_d = '0;
                taken_d    = (op_class == CLS_PC) && branch_taken(branch_mask, bus.flags);
                if (is_halt) begin
                    state_d = HALT;
                end else if (illegal) begin
                    state_d = FAULT;
                end else begin
                    state_d = EXECUTE;
                end
            end

            EXECUTE: begin
                case (op_class)
                    CLS_ALU: begin
                        alu_en  = 1'b1;
                        bus_sel = BUS_ALU;
                        state_d = ADVANCE;
                    end
                    CLS_ROM: begin
                        bus_sel = BUS_IMM;
                        state_d = ADVANCE;
                    end
                    CLS_RAM: begin
                        // Writes take their data from the ALU result.
                        ram_we  = is_write;
                        ram_re  = !is_write;
                        bus_sel = is_write ? BUS_ALU : BUS_RAM;
                        if (bus.ram_ready) begin
                            state_d = ADVANCE;
                        end else if (wait_cnt_q >= WAIT_LAST) begin
                            state_d = FAULT;
                        end else begin
                            wait_cnt_d = wait_cnt_q + 8'd1;
                        end
                    end
                    CLS_PC: begin
                        pc_load = taken_q;
                        state_d = ADVANCE;
                    end
                    default: state_d = FAULT;
                endcase
            end

            ADVANCE: begin
                // A taken branch already moved the PC, so no increment for it.
                pc_inc        = !taken_q;
                instr_count_d = instr_count_q + 16'd1;
                state_d       = FETCH;
            end

            HALT:    state_d = HALT;
            FAULT:   state_d = FAULT;
            default: state_d = FETCH;
        endcase
    end

    assign bus.ir_opcode   = ir_opcode_q;
    assign bus.ir_operand  = ir_operand_q;
    assign bus.alu_en      = alu_en;
    assign bus.ram_re      = ram_re;
    assign bus.ram_we      = ram_we;
    assign bus.pc_load     = pc_load;
    assign bus.pc_inc      = pc_inc;
    assign bus.bus_sel     = bus_sel;
    assign bus.halted      = (state_q == HALT);
    assign bus.fault       = (state_q == FAULT);
    assign bus.instr_count = instr_count_q;

endmodule

// File: tb/tb_fetch_decode_sequencer.sv
// Bench for fetch_decode_sequencer: a small ROM/PC environment plus an
// instruction-level reference model that predicts every cycle's outputs.
module tb_fetch_decode_sequencer;

    localparam int TMO = 8;

    logic        clk     = 1'b0;
    logic        reset   = 1'b0;
    logic [3:0]  flags_r = 4'h0;
    logic        ready_r = 1'b0;
    logic [15:0] rom_op  [64];
    logic [15:0] rom_opd [64];
    logic [15:0] env_pc;
    logic [15:0] m_pc;
    logic [15:0] m_count;
    int          n_checks = 0;
    int          n_errors = 0;

    always #5 clk = ~clk;

    fetch_decode_sequencer_if #(.DATA_WIDTH(16)) bus ();

    fetch_decode_sequencer #(
        .DATA_WIDTH  (16),
        .RAM_TIMEOUT (TMO),
        .HALT_WORD   (16'hFFFF)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    assign bus.rom_opcode  = rom_op[env_pc[5:0]];
    assign bus.rom_operand = rom_opd[env_pc[5:0]];
    assign bus.flags       = flags_r;
    assign bus.ram_ready   = ready_r;

    // Environment program counter obeying the sequencer's strobes.
    always @(posedge clk or negedge reset) begin
        if (!reset)           env_pc <= 16'h0000;
        else if (bus.pc_load) env_pc <= bus.ir_operand;
        else if (bus.pc_inc)  env_pc <= env_pc + 16'd1;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // {alu_en, ram_re, ram_we, pc_load, pc_inc, bus_sel, halted, fault}
    function automatic logic [8:0] outs();
        return {bus.alu_en, bus.ram_re, bus.ram_we, bus.pc_load, bus.pc_inc,
                bus.bus_sel, bus.halted, bus.fault};
    endfunction

    function automatic logic [8:0] ev(input bit alu, input bit re, input bit we, input bit ld,
                                      input bit inc, input logic [1:0] bs, input bit h, input bit f);
        return {alu, re, we, ld, inc, bs, h, f};
    endfunction

    task automatic step(input string tag, input logic [8:0] exp, input logic rdy);
        ready_r = rdy;
        check(tag, 32'(outs()), 32'(exp));
        @(posedge clk);
        #1;
    endtask

    task automatic term(input int n, input bit h);
        for (int i = 0; i < n; i++)
            step(h ? "halt_outs" : "fault_outs", ev(0, 0, 0, 0, 0, 2'b00, h, !h), 1'b0);
        check("frozen_count", 32'(bus.instr_count), 32'(m_count));
    endtask

    task automatic hold_reset();
        reset   = 1'b0;
        flags_r = 4'h0;
        ready_r = 1'b0;
        #1;
        check("rst_outs", 32'(outs()), 32'h0);
        check("rst_ir_opcode", 32'(bus.ir_opcode), 32'h0);
        check("rst_ir_operand", 32'(bus.ir_operand), 32'h0);
        check("rst_count", 32'(bus.instr_count), 32'h0);
        @(posedge clk);
        #1;
        m_pc    = 16'h0000;
        m_count = 16'h0000;
    endtask

    task automatic clear_rom();
        for (int a = 0; a < 64; a++) begin
            rom_op[a]  = 16'h1000;
            rom_opd[a] = 16'h0000;
        end
    endtask

    // Runs one instruction from the model's PC; stop=1 when it ends in HALT/FAULT.
    task automatic run_instr(input logic [3:0] fl, input int ram_wait, output bit stop);
        logic [15:0] op;
        logic [15:0] opd;
        bit          taken;
        bit          wr;
        int          n;
        op    = rom_op[m_pc[5:0]];
        opd   = rom_opd[m_pc[5:0]];
        stop  = 1'b0;
        taken = 1'b0;
        flags_r = fl;
        check("fetch_pc", 32'(env_pc), 32'(m_pc));
        step("fetch", ev(0, 0, 0, 0, 0, 2'b00, 0, 0), 1'b0);
        check("ir_opcode", 32'(bus.ir_opcode), 32'(op));
        check("ir_operand", 32'(bus.ir_operand), 32'(opd));
        step("decode", ev(0, 0, 0, 0, 0, 2'b00, 0, 0), 1'b0);
        if (op == 16'hFFFF) begin
            stop = 1'b1;
            term(100, 1'b1);
            return;
        end
        case (op[15:12])
            4'h1: step("exec_alu", ev(1, 0, 0, 0, 0, 2'b01, 0, 0), 1'b0);
            4'h3: step("exec_rom", ev(0, 0, 0, 0, 0, 2'b11, 0, 0), 1'b0);
            4'h4: begin
                wr = op[0];
                n  = (ram_wait < TMO) ? ram_wait + 1 : TMO;
                for (int i = 0; i < n; i++)
                    step(wr ? "exec_ram_wr" : "exec_ram_rd",
                         ev(0, !wr, wr, 0, 0, wr ? 2'b01 : 2'b10, 0, 0), (i == ram_wait));
                if (ram_wait >= TMO) begin
                    stop = 1'b1;
                    term(4, 1'b0);
                    return;
                end
            end
            4'h7: begin
                taken = (op[3:0] == 4'h0) || ((op[3:0] & fl) != 4'h0);
                step("exec_pc", ev(0, 0, 0, taken, 0, 2'b00, 0, 0), 1'b0);
            end
            default: begin
                stop = 1'b1;
                term(4, 1'b0);
                return;
            end
        endcase
        step("advance", ev(0, 0, 0, 0, !taken, 2'b00, 0, 0), 1'b0);
        m_count = m_count + 16'd1;
        check("instr_count", 32'(bus.instr_count), 32'(m_count));
        m_pc = taken ? opd : m_pc + 16'd1;
    endtask

    initial begin
        bit          stop;
        logic [15:0] op;
        int          r;
        int          w;

        // Directed program: ALU, taken/not-taken branch, RAM waits, timeout fault.
        clear_rom();
        hold_reset();
        rom_op[0]     = 16'h1000;
        rom_op[1]     = 16'h7001; rom_opd[1]    = 16'h0020;
        rom_op[6'h20] = 16'h7001; rom_opd[6'h20] = 16'h0005;
        rom_op[6'h21] = 16'h4000;
        rom_op[6'h22] = 16'h4000;
        rom_op[6'h23] = 16'h3ABC; rom_opd[6'h23] = 16'h1234;
        rom_op[6'h24] = 16'h4001;
        reset = 1'b1;
        run_instr(4'h0, 0, stop);
        run_instr(4'b0001, 0, stop);
        run_instr(4'h0, 0, stop);
        run_instr(4'h0, 3, stop);
        run_instr(4'h0, TMO - 1, stop);
        run_instr(4'h0, 0, stop);
        run_instr(4'h0, TMO + 5, stop);

        // Illegal opcode faults after DECODE.
        clear_rom();
        hold_reset();
        rom_op[0] = 16'h3000;
        rom_op[1] = 16'h2000;
        reset = 1'b1;
        run_instr(4'h0, 0, stop);
        run_instr(4'h0, 0, stop);

        // HALT_WORD stops with no strobes.
        clear_rom();
        hold_reset();
        rom_op[0] = 16'hFFFF;
        reset = 1'b1;
        run_instr(4'h0, 0, stop);

        // Reset asserted in the middle of a RAM wait.
        clear_rom();
        hold_reset();
        rom_op[0] = 16'h1000;
        rom_op[1] = 16'h4000;
        reset = 1'b1;
        run_instr(4'h0, 0, stop);
        step("mw_fetch", ev(0, 0, 0, 0, 0, 2'b00, 0, 0), 1'b0);
        step("mw_decode", ev(0, 0, 0, 0, 0, 2'b00, 0, 0), 1'b0);
        step("mw_req", ev(0, 1, 0, 0, 0, 2'b10, 0, 0), 1'b0);
        step("mw_req", ev(0, 1, 0, 0, 0, 2'b10, 0, 0), 1'b0);
        check("mw_ram_re", 32'(bus.ram_re), 32'h1);
        hold_reset();
        reset = 1'b1;
        run_instr(4'h0, 0, stop);
        run_instr(4'h0, 0, stop);

        // Randomized programs.
        for (int p = 0; p < 8; p++) begin
            hold_reset();
            for (int a = 0; a < 64; a++) begin
                r = int'($urandom_range(0, 39));
                op[11:0] = 12'($urandom);
                if (r < 10)      op[15:12] = 4'h1;
                else if (r < 18) op[15:12] = 4'h3;
                else if (r < 26) op[15:12] = 4'h4;
                else if (r < 37) op[15:12] = 4'h7;
                else if (r < 38) op[15:12] = 4'($urandom_range(8, 14));
                else if (r < 39) op[15:12] = 4'h0;
                else             op = 16'hFFFF;
                rom_op[a]  = op;
                rom_opd[a] = 16'($urandom_range(0, 63));
            end
            reset = 1'b1;
            stop  = 1'b0;
            for (int k = 0; k < 40 && !stop; k++) begin
                w = ($urandom_range(0, 9) == 0) ? TMO + int'($urandom_range(0, 2))
                                                : int'($urandom_range(0, TMO - 1));
                run_instr(4'($urandom), w, stop);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
